atm_account_bank: RTL and testbench

ATM_ACCOUNT_BANK -- requirements
Module: atm_account_bank

---
 rtl/atm_account_bank.sv | 179 +++++++++++++++++
 tb/tb_atm_account_bank.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_bank.sv
// ATM account bank: 8-entry balance/PIN/lock table with a session FSM that checks, verifies and commits transactions.
// Optional feature: define ATM_WITHDRAW_LIMIT_EN to cap the cumulative withdrawals per session at 500.
module atm_account_bank (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_req,
   input  logic [2:0]  card_id,
   input  logic [3:0]  pin_in,
   input  logic        pin_valid,
   input  logic        deposit_sel,
   input  logic        withdraw_sel,
   input  logic [15:0] amount,
   input  logic        amount_valid,
   input  logic        update_balance,
   input  logic        lock_acc,
   input  logic        end_session,
   output logic        account_locked,
   output logic        pin_matched,
   output logic        valid_transaction,
   output logic        transaction_verified,
   output logic [15:0] balance,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, LOOKUP, SESSION, CHECK, VERIFY, COMMIT} state_t;

   state_t      state_q, state_d;
   logic [2:0]  card_q, card_d;
   logic [15:0] bal_tbl_q [8];
   logic [15:0] bal_tbl_d [8];
   logic [3:0]  pin_tbl_q [8];
   logic [3:0]  pin_tbl_d [8];
   logic [7:0]  lock_tbl_q, lock_tbl_d;
   logic        pin_matched_q, pin_matched_d;
   logic        valid_q, valid_d;
   logic [15:0] amt_q, amt_d;
   logic        dep_q, dep_d;
   logic        wd_q, wd_d;
   logic [1:0]  vcnt_q, vcnt_d;

   logic [15:0] cur_bal;
   logic [16:0] dep_sum;
   logic        check_ok;

   assign cur_bal = bal_tbl_q[card_q];
   assign dep_sum = {1'b0, cur_bal} + {1'b0, amt_q};

`ifdef ATM_WITHDRAW_LIMIT_EN
   logic [16:0] acc_q, acc_d;
   logic        limit_ok;

   assign limit_ok = !wd_q || ((acc_q + {1'b0, amt_q}) <= 17'd500);
`else
   logic        limit_ok;

   assign limit_ok = 1'b1;
`endif

   // Exactly one transaction type, non-zero amount, no deposit overflow, no overdraw.
   assign check_ok = (amt_q != 16'd0) && (dep_q ^ wd_q) && !(dep_q && dep_sum[16])
                     && !(wd_q && (amt_q > cur_bal)) && limit_ok;

   assign busy                 = (state_q != IDLE);
   assign balance              = busy ? cur_bal : 16'd0;
   assign account_locked       = busy & lock_tbl_q[card_q];
   assign pin_matched          = pin_matched_q;
   assign valid_transaction    = valid_q;
   assign transaction_verified = (state_q == VERIFY) && (vcnt_q == 2'd2);

   always_comb begin
      state_d       = state_q;
      card_d        = card_q;
      bal_tbl_d     = bal_tbl_q;
      pin_tbl_d     = pin_tbl_q;
      lock_tbl_d    = lock_tbl_q;
      pin_matched_d = pin_matched_q;
      valid_d       = valid_q;
      amt_d         = amt_q;
      dep_d         = dep_q;
      wd_d          = wd_q;
      vcnt_d        = vcnt_q;
`ifdef ATM_WITHDRAW_LIMIT_EN
      acc_d         = acc_q;
`endif

      unique case (state_q)
         IDLE: begin
            if (lookup_req) begin
               card_d  = card_id;
               state_d = LOOKUP;
            end
         end
         LOOKUP: state_d = SESSION;
         SESSION: begin
            if (pin_valid) begin
               pin_matched_d = (pin_in == pin_tbl_q[card_q]) && !lock_tbl_q[card_q];
            end
            if (amount_valid && pin_matched_q) begin
               amt_d   = amount;
               dep_d   = deposit_sel;
               wd_d    = withdraw_sel;
               valid_d = 1'b0;
               state_d = CHECK;
            end
         end
         CHECK: begin
            valid_d = check_ok;
            vcnt_d  = 2'd0;
            state_d = check_ok ? VERIFY : SESSION;
         end
         VERIFY: begin
            if (vcnt_q == 2'd2) begin
               state_d = COMMIT;
            end else begin
               vcnt_d = vcnt_q + 2'd1;
            end
         end
         COMMIT: begin
            if (update_balance) begin
               bal_tbl_d[card_q] = dep_q ? dep_sum[15:0] : (cur_bal - amt_q);
`ifdef ATM_WITHDRAW_LIMIT_EN
               if (wd_q) acc_d = acc_q + {1'b0, amt_q};
`endif
               state_d = SESSION;
            end
         end
         default: state_d = IDLE;
      endcase

      // Session exits override everything above, including a same-cycle commit write.
      if (state_q != IDLE && (lock_acc || end_session)) begin
         if (lock_acc) lock_tbl_d[card_q] = 1'b1;
         bal_tbl_d     = bal_tbl_q;
         pin_matched_d = 1'b0;
         valid_d       = 1'b0;
         state_d       = IDLE;
`ifdef ATM_WITHDRAW_LIMIT_EN
         acc_d         = 17'd0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         card_q        <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            bal_tbl_q[i] <= 16'd1000;
            pin_tbl_q[i] <= 4'(i + 1);
         end
         lock_tbl_q    <= 8'd0;
         pin_matched_q <= 1'b0;
         valid_q       <= 1'b0;
         amt_q         <= 16'd0;
         dep_q         <= 1'b0;
         wd_q          <= 1'b0;
         vcnt_q        <= 2'd0;
`ifdef ATM_WITHDRAW_LIMIT_EN
         acc_q         <= 17'd0;
`endif
      end else begin
         state_q       <= state_d;
         card_q        <= card_d;
         bal_tbl_q     <= bal_tbl_d;
         pin_tbl_q     <= pin_tbl_d;
         lock_tbl_q    <= lock_tbl_d;
         pin_matched_q <= pin_matched_d;
         valid_q       <= valid_d;
         amt_q         <= amt_d;
         dep_q         <= dep_d;
         wd_q          <= wd_d;
         vcnt_q        <= vcnt_d;
`ifdef ATM_WITHDRAW_LIMIT_EN
         acc_q         <= acc_d;
`endif
      end
   end

endmodule

// File: tb/tb_atm_account_bank.sv
// Directed self-checking bench for atm_account_bank; inputs change and outputs are sampled on the falling edge.
module tb_atm_account_bank;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lookup_req = 1'b0;
   logic [2:0]  card_id = 3'd0;
   logic [3:0]  pin_in = 4'd0;
   logic        pin_valid = 1'b0;
   logic        deposit_sel = 1'b0;
   logic        withdraw_sel = 1'b0;
   logic [15:0] amount = 16'd0;
   logic        amount_valid = 1'b0;
   logic        update_balance = 1'b0;
   logic        lock_acc = 1'b0;
   logic        end_session = 1'b0;
   logic        account_locked;
   logic        pin_matched;
   logic        valid_transaction;
   logic        transaction_verified;
   logic [15:0] balance;
   logic        busy;

   int checks = 0;
   int passes = 0;

   atm_account_bank dut (
      .clk(clk), .rst(rst), .lookup_req(lookup_req), .card_id(card_id),
      .pin_in(pin_in), .pin_valid(pin_valid), .deposit_sel(deposit_sel),
      .withdraw_sel(withdraw_sel), .amount(amount), .amount_valid(amount_valid),
      .update_balance(update_balance), .lock_acc(lock_acc), .end_session(end_session),
      .account_locked(account_locked), .pin_matched(pin_matched),
      .valid_transaction(valid_transaction), .transaction_verified(transaction_verified),
      .balance(balance), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Leaves the DUT in LOOKUP; one more tick reaches SESSION.
   task automatic open_session(input logic [2:0] c);
      card_id = c;
      lookup_req = 1'b1;
      tick();
      lookup_req = 1'b0;
   endtask

   task automatic enter_pin(input logic [3:0] p);
      pin_in = p;
      pin_valid = 1'b1;
      tick();
      pin_valid = 1'b0;
   endtask

   // Leaves the DUT in CHECK when the amount is accepted.
   task automatic enter_amount(input logic [15:0] a, input logic dep, input logic wd);
      amount = a;
      deposit_sel = dep;
      withdraw_sel = wd;
      amount_valid = 1'b1;
      tick();
      amount_valid = 1'b0;
   endtask

   task automatic close_session();
      end_session = 1'b1;
      tick();
      end_session = 1'b0;
   endtask

   // From CHECK with a valid amount: through VERIFY, then commit.
   task automatic run_commit();
      repeat (3) tick();
      update_balance = 1'b1;
      tick();
      tick();
      update_balance = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b expected 0", busy); else passes++;
      checks++; if (balance !== 16'd0) $display("[TB] FAIL reset_balance: got %0d expected 0", balance); else passes++;
      checks++; if (pin_matched !== 1'b0) $display("[TB] FAIL reset_pin_matched: got %0b expected 0", pin_matched); else passes++;
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL reset_valid: got %0b expected 0", valid_transaction); else passes++;
      checks++; if (transaction_verified !== 1'b0) $display("[TB] FAIL reset_verified: got %0b expected 0", transaction_verified); else passes++;
      checks++; if (account_locked !== 1'b0) $display("[TB] FAIL reset_locked: got %0b expected 0", account_locked); else passes++;
   endtask

   task automatic test_lookup_pin();
      open_session(3'd2);
      checks++; if (busy !== 1'b1) $display("[TB] FAIL lookup_busy: got %0b expected 1", busy); else passes++;
      checks++; if (balance !== 16'd1000) $display("[TB] FAIL lookup_balance: got %0d expected 1000", balance); else passes++;
      checks++; if (account_locked !== 1'b0) $display("[TB] FAIL lookup_locked: got %0b expected 0", account_locked); else passes++;
      tick();
      enter_pin(4'd4);
      checks++; if (pin_matched !== 1'b0) $display("[TB] FAIL pin_wrong: got %0b expected 0", pin_matched); else passes++;
      enter_pin(4'd3);
      checks++; if (pin_matched !== 1'b1) $display("[TB] FAIL pin_right: got %0b expected 1", pin_matched); else passes++;
   endtask

   task automatic test_deposit();
      enter_amount(16'd250, 1'b1, 1'b0);
      tick();
      checks++; if (valid_transaction !== 1'b1) $display("[TB] FAIL dep_valid: got %0b expected 1", valid_transaction); else passes++;
      tick();
      checks++; if (transaction_verified !== 1'b0) $display("[TB] FAIL dep_verified_early: got %0b expected 0", transaction_verified); else passes++;
      tick();
      checks++; if (transaction_verified !== 1'b1) $display("[TB] FAIL dep_verified_pulse: got %0b expected 1", transaction_verified); else passes++;
      update_balance = 1'b1;
      tick();
      checks++; if (transaction_verified !== 1'b0) $display("[TB] FAIL dep_verified_width: got %0b expected 0", transaction_verified); else passes++;
      checks++; if (balance !== 16'd1000) $display("[TB] FAIL dep_balance_pre: got %0d expected 1000", balance); else passes++;
      tick();
      update_balance = 1'b0;
      checks++; if (balance !== 16'd1250) $display("[TB] FAIL dep_balance_post: got %0d expected 1250", balance); else passes++;
      close_session();
   endtask

   task automatic test_invalid_amounts();
      open_session(3'd0);
      tick();
      enter_pin(4'd1);
      enter_amount(16'd1001, 1'b0, 1'b1);
      tick();
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL overdraw_valid: got %0b expected 0", valid_transaction); else passes++;
      checks++; if (balance !== 16'd1000) $display("[TB] FAIL overdraw_balance: got %0d expected 1000", balance); else passes++;
      // A following amount is only accepted if the FSM went back to SESSION.
      enter_amount(16'd65000, 1'b1, 1'b0);
      tick();
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL overflow_valid: got %0b expected 0", valid_transaction); else passes++;
      enter_amount(16'd10, 1'b1, 1'b1);
      tick();
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL both_sel_valid: got %0b expected 0", valid_transaction); else passes++;
      enter_amount(16'd0, 1'b1, 1'b0);
      tick();
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL zero_amount_valid: got %0b expected 0", valid_transaction); else passes++;
      enter_amount(16'd200, 1'b0, 1'b1);
      tick();
      checks++; if (valid_transaction !== 1'b1) $display("[TB] FAIL wd200_valid: got %0b expected 1", valid_transaction); else passes++;
      tick();
      close_session();
      checks++; if (busy !== 1'b0) $display("[TB] FAIL end_in_verify_busy: got %0b expected 0", busy); else passes++;
      open_session(3'd0);
      checks++; if (balance !== 16'd1000) $display("[TB] FAIL end_in_verify_balance: got %0d expected 1000", balance); else passes++;
      close_session();
   endtask

   task automatic test_lock();
      open_session(3'd5);
      tick();
      enter_pin(4'd6);
      lock_acc = 1'b1;
      end_session = 1'b1;
      tick();
      lock_acc = 1'b0;
      end_session = 1'b0;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL lock_busy: got %0b expected 0", busy); else passes++;
      checks++; if (pin_matched !== 1'b0) $display("[TB] FAIL lock_pin_cleared: got %0b expected 0", pin_matched); else passes++;
      close_session();
      open_session(3'd5);
      checks++; if (account_locked !== 1'b1) $display("[TB] FAIL relookup_locked: got %0b expected 1", account_locked); else passes++;
      tick();
      enter_pin(4'd6);
      checks++; if (pin_matched !== 1'b0) $display("[TB] FAIL locked_pin: got %0b expected 0", pin_matched); else passes++;
      close_session();
   endtask

   task automatic test_back_to_back_withdraw();
      logic exp_second;
`ifdef ATM_WITHDRAW_LIMIT_EN
      exp_second = 1'b0;
`else
      exp_second = 1'b1;
`endif
      open_session(3'd3);
      tick();
      enter_pin(4'd4);
      enter_amount(16'd300, 1'b0, 1'b1);
      run_commit();
      checks++; if (balance !== 16'd700) $display("[TB] FAIL wd300_balance: got %0d expected 700", balance); else passes++;
      enter_amount(16'd300, 1'b0, 1'b1);
      tick();
      checks++; if (valid_transaction !== exp_second) $display("[TB] FAIL wd300_second_valid: got %0b expected %0b", valid_transaction, exp_second); else passes++;
      close_session();
      open_session(3'd3);
      checks++; if (balance !== 16'd700) $display("[TB] FAIL wd_table_balance: got %0d expected 700", balance); else passes++;
      close_session();
   endtask

   task automatic test_reset_mid();
      open_session(3'd2);
      checks++; if (balance !== 16'd1250) $display("[TB] FAIL card2_kept: got %0d expected 1250", balance); else passes++;
      tick();
      enter_pin(4'd3);
      enter_amount(16'd5, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %0b expected 0", busy); else passes++;
      checks++; if (valid_transaction !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %0b expected 0", valid_transaction); else passes++;
      open_session(3'd2);
      checks++; if (balance !== 16'd1000) $display("[TB] FAIL rst_mid_reload: got %0d expected 1000", balance); else passes++;
      close_session();
   endtask

   initial begin
      test_reset();
      test_lookup_pin();
      test_deposit();
      test_invalid_amounts();
      test_lock();
      test_back_to_back_withdraw();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
